// File: rtl/hilo_sched.sv
// Issue queue, latency timer and write-back sequencer for the shared mult/div unit
// that owns HI/LO; also drives the LO tracker pulses and the mfhi/mflo stall.
module hilo_sched #(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_vld,
  input  logic                     issue_is_div,
  output logic                     issue_rdy,
  input  logic                     mf_req,
  output logic                     mf_stall,
  output logic                     unit_start,
  output logic                     unit_is_div,
  output logic                     hilo_we,
  output logic                     wreg,
  output logic                     wreg_wb,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   outstanding
);

  // state | meaning
  // IDLE  | unit free; launch queue head if any
  // EXEC  | unit running, cnt counts down remaining cycles
  // WB    | result written to HI/LO this cycle, then back to IDLE

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [OW-1:0]    OCC_ONE  = OW'(1);
  localparam logic [OW-1:0]    OCC_MAX  = OW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DEPTH-1:0] q_mem;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [OW-1:0]    q_cnt;
  logic             accept;
  logic             head_div;

  // Ready looks only at registered occupancy, so a same-cycle retire cannot raise it.
  assign issue_rdy = (outstanding < OCC_MAX);
  assign accept    = issue_vld & issue_rdy;
  assign wreg      = accept;
  assign wreg_wb   = hilo_we;
  assign mf_stall  = mf_req & (outstanding != '0);
  assign busy      = (state != IDLE) | (q_cnt != '0);
  assign head_div  = q_mem[rd_ptr];

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    unit_start  = 1'b0;
    unit_is_div = 1'b0;
    hilo_we     = 1'b0;
    case (state)
      IDLE: begin
        if (q_cnt != '0) begin
          unit_start  = 1'b1;
          unit_is_div = head_div;
          cnt_nxt     = head_div ? DIV_LOAD : MUL_LOAD;
          state_nxt   = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) state_nxt = WB;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
      WB: begin
        hilo_we   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Queue: pushes land at the end of the accept cycle, so a new op is never
  // visible to IDLE until the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_mem  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (accept) begin
        q_mem[wr_ptr] <= issue_is_div;
        wr_ptr        <= wr_ptr + PTR_ONE;
      end
      if (unit_start) rd_ptr <= rd_ptr + PTR_ONE;
      case ({accept, unit_start})
        2'b10:   q_cnt <= q_cnt + OCC_ONE;
        2'b01:   q_cnt <= q_cnt - OCC_ONE;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, hilo_we})
        2'b10:   outstanding <= outstanding + OCC_ONE;
        2'b01:   outstanding <= outstanding - OCC_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_sched.sv
// Directed and random stimulus for hilo_sched checked each cycle against an
// op-list timing model (start = max(accept+1, prev_wb+1), wb = start+LAT+1).
module tb_hilo_sched;

  localparam int DEPTH   = 4;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 6;
  localparam int OW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_vld = 1'b0;
  logic          issue_is_div = 1'b0;
  logic          mf_req = 1'b0;
  logic          issue_rdy, mf_stall, unit_start, unit_is_div;
  logic          hilo_we, wreg, wreg_wb, busy;
  logic [OW-1:0] outstanding;

  hilo_sched #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_vld(issue_vld), .issue_is_div(issue_is_div), .issue_rdy(issue_rdy),
    .mf_req(mf_req), .mf_stall(mf_stall),
    .unit_start(unit_start), .unit_is_div(unit_is_div),
    .hilo_we(hilo_we), .wreg(wreg), .wreg_wb(wreg_wb),
    .busy(busy), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int start;
    int wb;
    bit div;
  } op_t;

  op_t ops[$];
  int  cyc = 0;
  int  last_wb = -100;
  int  n_cmp = 0;
  int  n_fail = 0;
  int  we_count = 0;
  int  last_we_cyc = -1;
  int  last_start_cyc = -1;
  bit  last_start_div = 1'b0;
  bit  obs_wreg = 1'b0;
  bit  obs_stall = 1'b0;
  int  peak_out = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive after negedge, check outputs, then advance the model.
  task automatic step(input bit v, input bit d, input bit m);
    int  e_out;
    bit  e_rdy, e_acc, e_start, e_div, e_we;
    op_t op;
    @(negedge clk);
    issue_vld = v;
    issue_is_div = d;
    mf_req = m;
    #1;
    while (ops.size() != 0 && ops[0].wb < cyc) void'(ops.pop_front());
    e_out   = ops.size();
    e_rdy   = (e_out < DEPTH);
    e_acc   = v & e_rdy;
    e_start = 1'b0;
    e_div   = 1'b0;
    e_we    = 1'b0;
    foreach (ops[i]) begin
      if (ops[i].start == cyc) begin
        e_start = 1'b1;
        e_div   = ops[i].div;
      end
      if (ops[i].wb == cyc) e_we = 1'b1;
    end
    chk("issue_rdy", issue_rdy, e_rdy);
    chk("wreg", wreg, e_acc);
    chk("unit_start", unit_start, e_start);
    if (e_start) chk("unit_is_div", unit_is_div, e_div);
    chk("hilo_we", hilo_we, e_we);
    chk("wreg_wb", wreg_wb, e_we);
    chk("outstanding", outstanding, e_out);
    chk("busy", busy, e_out != 0);
    chk("mf_stall", mf_stall, m & (e_out != 0));
    obs_wreg  = wreg;
    obs_stall = mf_stall;
    if (hilo_we === 1'b1) begin
      we_count++;
      last_we_cyc = cyc;
    end
    if (unit_start === 1'b1) begin
      last_start_cyc = cyc;
      last_start_div = unit_is_div;
    end
    if (int'(outstanding) > peak_out) peak_out = int'(outstanding);
    if (e_acc) begin
      op.acc   = cyc;
      op.div   = d;
      op.start = (cyc + 1 > last_wb + 1) ? cyc + 1 : last_wb + 1;
      op.wb    = op.start + (d ? DIV_LAT : MUL_LAT) + 1;
      last_wb  = op.wb;
      ops.push_back(op);
    end
    cyc++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (ops.size() != 0 && ops[ops.size()-1].wb >= cyc && k < 300) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
    end
    if (k >= 300) chk("drain_timeout", k, 0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    issue_vld = 1'b0;
    issue_is_div = 1'b0;
    mf_req = 1'b1;
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_busy", busy, 0);
    chk("rst_issue_rdy", issue_rdy, 1);
    chk("rst_mf_stall", mf_stall, 0);
    chk("rst_unit_start", unit_start, 0);
    chk("rst_hilo_we", hilo_we, 0);
    repeat (hold) begin
      @(negedge clk);
      #1;
      chk("rst_hold_hilo_we", hilo_we, 0);
      chk("rst_hold_wreg_wb", wreg_wb, 0);
    end
    mf_req = 1'b0;
    rst_n = 1'b1;
    cyc += hold + 1;
    ops.delete();
    last_wb = -100;
  endtask

  initial begin
    int base, we0, n_acc, acc_cyc, clear_cyc;

    do_reset(2);

    // Single multiply
    base = cyc;
    we0 = we_count;
    step(1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b0);
    chk("mul_start_cyc", last_start_cyc - base, 1);
    chk("mul_we_cyc", last_we_cyc - base, 5);
    chk("mul_we_count", we_count - we0, 1);

    // Mult then div back to back
    base = cyc;
    peak_out = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    drain();
    chk("div_start_cyc", last_start_cyc - base, 6);
    chk("div_start_isdiv", last_start_div, 1);
    chk("div_we_cyc", last_we_cyc - base, 39);
    chk("peak_outstanding", peak_out, 2);

    // Back-pressure: five ops with issue_vld held high
    base = cyc;
    we0 = we_count;
    n_acc = 0;
    acc_cyc = -1;
    for (int k = 0; k < 100 && n_acc < 5; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (obs_wreg) begin
        n_acc++;
        acc_cyc = cyc - 1;
      end
    end
    chk("bp_accepts", n_acc, 5);
    chk("bp_fifth_accept_cyc", acc_cyc - base, 6);
    drain();
    chk("bp_we_count", we_count - we0, 5);

    // mf hazard: mult then mf_req held
    base = cyc;
    clear_cyc = -1;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20 && clear_cyc < 0; k++) begin
      step(1'b0, 1'b0, 1'b1);
      if (!obs_stall) clear_cyc = cyc - 1;
    end
    chk("mf_clear_cyc", clear_cyc - base, 6);
    step(1'b1, 1'b0, 1'b1);
    chk("mf_same_cycle_accept", obs_stall, 0);
    drain();

    // Accept in the write-back cycle of a prior op
    base = cyc;
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("sim_we_cyc", last_we_cyc - base, 5);
    step(1'b0, 1'b0, 1'b0);
    chk("sim_start_cyc", last_start_cyc - base, 6);
    chk("sim_start_isdiv", last_start_div, 1);
    drain();

    // Reset mid-divide with one op queued
    base = cyc;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    while (cyc < base + 10) step(1'b0, 1'b0, 1'b0);
    do_reset(2);
    we0 = we_count;
    repeat (50) step(1'b0, 1'b0, 1'b0);
    chk("post_rst_no_we", we_count - we0, 0);
    base = cyc;
    step(1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b0);
    chk("post_rst_mul_start", last_start_cyc - base, 1);
    chk("post_rst_mul_we", last_we_cyc - base, 5);

    // Random traffic
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
